// File: rtl/rle_quant_encoder.sv
// Run-length / quantizing encoder for 8-coefficient DCT blocks.
// Accepts a block, quantizes all coefficients in one cycle, then scans them
// one per cycle and emits (run, level) tokens, terminated by one EOB token.
module rle_quant_encoder #(
    parameter int COEF_W  = 18,
    parameter int QSHIFT  = 4,
    parameter int LEVEL_W = 12,
    parameter int RUN_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [8*COEF_W-1:0]       coef_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RUN_W-1:0]          out_run,
    output logic signed [LEVEL_W-1:0] out_level,
    output logic                      out_eob,
    output logic                      busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
    localparam logic [1:0] EOB  = 2'd3;

    // Wide enough to hold the biased coefficient and compare against level limits.
    localparam int XW = COEF_W + LEVEL_W + 1;
    localparam logic signed [XW-1:0] QBIAS = XW'((1 << QSHIFT) - 1);
    localparam logic signed [XW-1:0] LMAX  = XW'((1 << (LEVEL_W - 1)) - 1);
    localparam logic signed [XW-1:0] LMIN  = ~LMAX;

    logic [1:0]                state;
    logic [2:0]                idx;
    logic [RUN_W-1:0]          run;
    logic signed [LEVEL_W-1:0] levels [8];
    logic signed [LEVEL_W-1:0] cur;

    // Round toward zero (bias negatives before the arithmetic shift), then saturate.
    function automatic logic signed [LEVEL_W-1:0] quant(input logic signed [COEF_W-1:0] c);
        logic signed [XW-1:0] t;
        t = {{(XW-COEF_W){c[COEF_W-1]}}, c};
        if (c[COEF_W-1])
            t = t + QBIAS;
        t = t >>> QSHIFT;
        if (t > LMAX)
            t = LMAX;
        else if (t < LMIN)
            t = LMIN;
        return t[LEVEL_W-1:0];
    endfunction

    assign blk_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Level under examination in SCAN.
    always_comb begin
        cur = levels[idx];
    end

    // Block capture, scan sequencing and registered token output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            run       <= '0;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_level <= '0;
            out_eob   <= 1'b0;
            for (int unsigned k = 0; k < 8; k++)
                levels[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int unsigned k = 0; k < 8; k++)
                            levels[k] <= quant(coef_in[k*COEF_W +: COEF_W]);
                        idx   <= '0;
                        run   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur == '0) begin
                        if (idx != 3'd7) begin
                            run <= run + RUN_W'(1);
                            idx <= idx + 3'd1;
                        end else begin
                            out_valid <= 1'b1;
                            out_run   <= run + RUN_W'(1);
                            out_level <= '0;
                            out_eob   <= 1'b1;
                            state     <= EOB;
                        end
                    end else begin
                        out_valid <= 1'b1;
                        out_run   <= run;
                        out_level <= cur;
                        out_eob   <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    // out_valid is always high here, so out_ready alone marks the handshake.
                    if (out_ready) begin
                        run <= '0;
                        if (idx != 3'd7) begin
                            idx       <= idx + 3'd1;
                            out_valid <= 1'b0;
                            state     <= SCAN;
                        end else begin
                            out_run   <= '0;
                            out_level <= '0;
                            out_eob   <= 1'b1;
                            state     <= EOB;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_run   <= '0;
                        out_level <= '0;
                        out_eob   <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_quant_encoder.sv
// Directed bench for rle_quant_encoder: latency, quantization, saturation,
// backpressure, mid-block reset and a short randomized run against a model.
module tb_rle_quant_encoder;

    logic               clk = 1'b0;
    logic               reset;
    logic               blk_valid;
    logic               blk_ready;
    logic [8*18-1:0]    coef_in;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_run;
    logic signed [11:0] out_level;
    logic               out_eob;
    logic               busy;

    typedef struct {
        int run;
        int level;
        int eob;
        int dt;
    } tok_t;

    tok_t q[$];
    tok_t exp_q[$];
    int   cyc = 0;
    int   t_acc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cv[8];

    rle_quant_encoder #(.COEF_W(18), .QSHIFT(4), .LEVEL_W(12), .RUN_W(4)) dut (
        .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .coef_in(coef_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_run(out_run), .out_level(out_level), .out_eob(out_eob), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record acceptances and token handshakes with their cycle offset.
    always @(posedge clk) begin
        tok_t t;
        if (reset) begin
            if (blk_valid && blk_ready)
                t_acc = cyc;
            if (out_valid && out_ready) begin
                t.run   = int'(out_run);
                t.level = int'(out_level);
                t.eob   = int'(out_eob);
                t.dt    = cyc - t_acc;
                q.push_back(t);
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_tok(input string tag, input int i, input int run, input int level,
                           input int eob, input int dt);
        if (i >= q.size()) begin
            check({tag, "_present"}, q.size(), i + 1);
        end else begin
            check({tag, "_run"}, q[i].run, run);
            check({tag, "_level"}, q[i].level, level);
            check({tag, "_eob"}, q[i].eob, eob);
            if (dt >= 0)
                check({tag, "_dt"}, q[i].dt, dt);
        end
    endtask

    task automatic send_block();
        int acc;
        acc = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            coef_in[k*18 +: 18] = cv[k][17:0];
        blk_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (blk_ready) begin
                acc = 1;
                break;
            end
        end
        @(negedge clk);
        blk_valid = 1'b0;
        check("accept", acc, 1);
    endtask

    // Wait for this block's EOB token; optionally randomize out_ready meanwhile.
    task automatic wait_eob(input int rnd);
        int seen;
        seen = 0;
        for (int n = 0; n < 300; n++) begin
            if (q.size() > 0 && q[q.size()-1].eob == 1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            if (rnd != 0)
                out_ready = ($urandom_range(0, 3) != 0);
        end
        if (seen == 0)
            check("eob_timeout", seen, 1);
    endtask

    task automatic wait_valid();
        int seen;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("valid_seen", seen, 1);
    endtask

    function automatic int gq(input int c);
        int v;
        v = c / 16;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    initial begin
        int r;
        int sum;
        tok_t t;
        reset     = 1'b0;
        blk_valid = 1'b0;
        out_ready = 1'b1;
        coef_in   = '0;

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_eob", int'(out_eob), 0);
        check("rst_out_run", int'(out_run), 0);
        check("rst_out_level", int'(out_level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_blk_ready", int'(blk_ready), 1);
        @(negedge clk);
        reset = 1'b1;

        // All-zero block: single EOB run=8, 9 cycles after acceptance.
        q.delete();
        cv = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_block();
        wait_eob(0);
        check("zero_count", q.size(), 1);
        chk_tok("zero_eob", 0, 8, 0, 1, 9);
        @(negedge clk);
        check("zero_ready_after", int'(blk_ready), 1);

        // Mixed block with toward-zero rounding.
        q.delete();
        cv = '{160, 0, 0, -33, 0, 0, 0, 5};
        send_block();
        wait_eob(0);
        check("mix_count", q.size(), 3);
        chk_tok("mix_t0", 0, 0, 10, 0, 2);
        chk_tok("mix_t1", 1, 2, -2, 0, 6);
        chk_tok("mix_eob", 2, 4, 0, 1, 11);

        // Saturation at both ends.
        q.delete();
        cv = '{131071, -131072, 1, 1, 1, 1, 1, 16};
        send_block();
        wait_eob(0);
        check("sat_count", q.size(), 4);
        chk_tok("sat_t0", 0, 0, 2047, 0, 2);
        chk_tok("sat_t1", 1, 0, -2048, 0, 4);
        chk_tok("sat_t2", 2, 5, 1, 0, 11);
        chk_tok("sat_eob", 3, 0, 0, 1, 12);

        // All-nonzero block: tokens every 2 cycles, EOB at +17.
        q.delete();
        cv = '{16, -16, 32, -32, 48, -48, 64, -64};
        send_block();
        wait_eob(0);
        check("full_count", q.size(), 9);
        for (int i = 0; i < 8; i++)
            chk_tok("full_t", i, 0, ((i % 2) == 0) ? (i / 2 + 1) : -(i / 2 + 1), 0, 2 * i + 2);
        chk_tok("full_eob", 8, 0, 0, 1, 17);

        // Backpressure with ignored blk_valid pulses while busy.
        q.delete();
        out_ready = 1'b0;
        cv = '{0, 0, 16, 0, 0, 0, 0, 0};
        send_block();
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            blk_valid = (i % 2) == 0;
            coef_in   = {8{18'h00100}};
            check("bp_valid", int'(out_valid), 1);
            check("bp_run", int'(out_run), 2);
            check("bp_level", int'(out_level), 1);
            check("bp_eob", int'(out_eob), 0);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        out_ready = 1'b1;
        wait_eob(0);
        repeat (20) @(negedge clk);
        check("bp_count", q.size(), 2);
        chk_tok("bp_t0", 0, 2, 1, 0, -1);
        chk_tok("bp_eob", 1, 5, 0, 1, -1);
        check("bp_idle_ready", int'(blk_ready), 1);

        // Reset while the second token is waiting in EMIT.
        q.delete();
        out_ready = 1'b0;
        cv = '{16, 16, 0, 0, 0, 0, 0, 0};
        send_block();
        wait_valid();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_valid();
        #2;
        reset = 1'b0;
        #1;
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_out_run", int'(out_run), 0);
        check("mrst_out_level", int'(out_level), 0);
        check("mrst_out_eob", int'(out_eob), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_blk_ready", int'(blk_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("mrst_no_eob", q.size(), 1);
        q.delete();
        cv = '{0, 0, 0, 16, 0, 0, 0, 0};
        send_block();
        wait_eob(0);
        check("post_count", q.size(), 2);
        chk_tok("post_t0", 0, 3, 1, 0, 5);
        chk_tok("post_eob", 1, 4, 0, 1, -1);

        // Randomized blocks with random out_ready against a reference model.
        for (int b = 0; b < 8; b++) begin
            q.delete();
            exp_q.delete();
            for (int k = 0; k < 8; k++) begin
                r = int'($urandom_range(0, 3));
                if (r == 0)
                    cv[k] = int'($urandom_range(0, 262143)) - 131072;
                else
                    cv[k] = int'($urandom_range(0, 80)) - 40;
            end
            r = 0;
            for (int k = 0; k < 8; k++) begin
                if (gq(cv[k]) == 0) begin
                    r++;
                end else begin
                    t.run = r; t.level = gq(cv[k]); t.eob = 0; t.dt = -1;
                    exp_q.push_back(t);
                    r = 0;
                end
            end
            t.run = r; t.level = 0; t.eob = 1; t.dt = -1;
            exp_q.push_back(t);
            send_block();
            wait_eob(1);
            check("rnd_count", q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++)
                chk_tok("rnd_tok", i, exp_q[i].run, exp_q[i].level, exp_q[i].eob, -1);
            sum = 0;
            for (int i = 0; i < q.size(); i++)
                sum += q[i].run + ((q[i].eob == 0) ? 1 : 0);
            check("rnd_sum8", sum, 8);
        end
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
